// File: rtl/lane_pkg.sv
// Shared types, default parameters and arithmetic helpers for the lane tracker.
package lane_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_SELECT,
    S_CALC,
    S_SEND
  } lane_state_e;

  localparam int DEF_N_PIX      = 32;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_MAX_PEAKS  = 4;
  localparam int DEF_LOST_LIMIT = 4;

  function automatic logic [15:0] abs16(input logic signed [15:0] v);
    return v[15] ? 16'(-v) : 16'(v);
  endfunction

  function automatic logic [7:0] sat_add8(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = 17'(a) + 17'(b);
    return (s > 17'd255) ? 8'hFF : s[7:0];
  endfunction

  // Number of SELECT cycles: one per pair, but never fewer than one.
  function automatic logic [7:0] pair_cycles(input logic [7:0] p);
    return (p < 8'd2) ? 8'd1 : 8'((16'(p) * 16'(p - 8'd1)) >> 1);
  endfunction

endpackage

// File: rtl/lane_tracker_if.sv
// Pixel-in / result-out handshake bundle of the lane tracker.
interface lane_tracker_if #(parameter int PIX_W = 8);
  logic [PIX_W-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic [7:0]       confidence;
  logic             lane_lost;
  logic             out_valid;
  logic             out_ready;

  modport master (output rx_data, rx_valid, out_ready,
                  input  rx_ready, tx_data, confidence, lane_lost, out_valid);
  modport slave  (input  rx_data, rx_valid, out_ready,
                  output rx_ready, tx_data, confidence, lane_lost, out_valid);
endinterface

// File: rtl/lane_pair_selector.sv
// Walks every peak pair once per cycle and keeps the eligible pair closest to last_center.
module lane_pair_selector
  import lane_pkg::*;
#(
  parameter  int MAX_PEAKS = DEF_MAX_PEAKS,
  localparam int IW        = $clog2(MAX_PEAKS),
  localparam int CNW       = $clog2(MAX_PEAKS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [CNW-1:0] peak_cnt,
  input  logic [7:0]     peak_pos [MAX_PEAKS],
  input  logic [7:0]     last_center,
  input  logic [7:0]     min_width,
  input  logic [7:0]     max_width,
  output logic [IW-1:0]  best_i,
  output logic [IW-1:0]  best_j,
  output logic           found,
  output logic           done
);

  logic [IW-1:0] i_q, i_d, j_q, j_d, best_i_q, best_i_d, best_j_q, best_j_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   best_metric_q, best_metric_d;
  logic          found_q, found_d;

  logic [7:0]  pos_i, pos_j, width, centre, total;
  logic [15:0] metric;
  logic        eligible, better;

  assign total    = pair_cycles(8'(peak_cnt));
  assign pos_i    = peak_pos[i_q];
  assign pos_j    = peak_pos[j_q];
  assign width    = pos_j - pos_i;
  assign centre   = 8'((9'(pos_i) + 9'(pos_j)) >> 1);
  assign metric   = abs16($signed(16'(centre) - 16'(last_center)));
  assign eligible = run && (peak_cnt >= CNW'(2)) &&
                    (width >= min_width) && (width <= max_width);
  // Strict compare so that on a tie the earlier pair in scan order wins.
  assign better   = eligible && (!found_q || (metric < best_metric_q));
  assign done     = run && (cnt_q == total - 8'd1);

  always_comb begin
    i_d           = i_q;
    j_d           = j_q;
    cnt_d         = cnt_q;
    best_i_d      = best_i_q;
    best_j_d      = best_j_q;
    best_metric_d = best_metric_q;
    found_d       = found_q;
    if (!run) begin
      i_d           = '0;
      j_d           = IW'(1);
      cnt_d         = '0;
      best_i_d      = '0;
      best_j_d      = '0;
      best_metric_d = '0;
      found_d       = 1'b0;
    end else begin
      if (better) begin
        best_i_d      = i_q;
        best_j_d      = j_q;
        best_metric_d = metric;
        found_d       = 1'b1;
      end
      cnt_d = cnt_q + 8'd1;
      if (CNW'(j_q) == peak_cnt - CNW'(1)) begin
        i_d = i_q + IW'(1);
        j_d = i_q + IW'(2);
      end else begin
        j_d = j_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q           <= '0;
      j_q           <= IW'(1);
      cnt_q         <= '0;
      best_i_q      <= '0;
      best_j_q      <= '0;
      best_metric_q <= '0;
      found_q       <= 1'b0;
    end else begin
      i_q           <= i_d;
      j_q           <= j_d;
      cnt_q         <= cnt_d;
      best_i_q      <= best_i_d;
      best_j_q      <= best_j_d;
      best_metric_q <= best_metric_d;
      found_q       <= found_d;
    end
  end

  assign best_i = best_i_q;
  assign best_j = best_j_q;
  assign found  = found_q;

endmodule

// File: rtl/lane_tracker.sv
// Row-by-row lane centre tracker: edge peaks -> best pair -> centre/confidence.
// Optional LANE_SMOOTH_EN averages a found centre with the previous one.
module lane_tracker
  import lane_pkg::*;
#(
  parameter int N_PIX      = DEF_N_PIX,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int MAX_PEAKS  = DEF_MAX_PEAKS,
  parameter int LOST_LIMIT = DEF_LOST_LIMIT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [PIX_W:0] threshold,
  input  logic [7:0]     min_width,
  input  logic [7:0]     max_width,
  output logic           busy,
  lane_tracker_if.slave  bus
);

  localparam int         CW   = $clog2(N_PIX);
  localparam int         IW   = $clog2(MAX_PEAKS);
  localparam int         CNW  = $clog2(MAX_PEAKS + 1);
  localparam int         MW   = PIX_W + 1;
  localparam logic [7:0] HALF = 8'(N_PIX / 2);

  lane_state_e    state_q, state_d;
  logic [CW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [CNW-1:0] peak_cnt_q, peak_cnt_d;
  logic [7:0]     peak_pos_q [MAX_PEAKS];
  logic [7:0]     peak_pos_d [MAX_PEAKS];
  logic [MW-1:0]  peak_mag_q [MAX_PEAKS];
  logic [MW-1:0]  peak_mag_d [MAX_PEAKS];
  logic [7:0]     last_center_q, last_center_d, lost_cnt_q, lost_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d, conf_q, conf_d;

  logic [IW-1:0]  sel_best_i, sel_best_j;
  logic           sel_found, sel_done;
  logic [15:0]    mag;
  logic [7:0]     centre;

  assign mag    = abs16($signed(16'(bus.rx_data) - 16'(p2_q)));
  assign centre = 8'((9'(peak_pos_q[sel_best_i]) + 9'(peak_pos_q[sel_best_j])) >> 1);

  lane_pair_selector #(.MAX_PEAKS(MAX_PEAKS)) u_sel (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (state_q == S_SELECT),
    .peak_cnt    (peak_cnt_q),
    .peak_pos    (peak_pos_q),
    .last_center (last_center_q),
    .min_width   (min_width),
    .max_width   (max_width),
    .best_i      (sel_best_i),
    .best_j      (sel_best_j),
    .found       (sel_found),
    .done        (sel_done)
  );

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    peak_cnt_d    = peak_cnt_q;
    peak_pos_d    = peak_pos_q;
    peak_mag_d    = peak_mag_q;
    last_center_d = last_center_q;
    lost_cnt_d    = lost_cnt_q;
    tx_data_d     = tx_data_q;
    conf_d        = conf_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_RECEIVE;
        pix_cnt_d  = '0;
        peak_cnt_d = '0;
      end
      S_RECEIVE: if (bus.rx_valid) begin
        p1_d      = bus.rx_data;
        p2_d      = p1_q;
        pix_cnt_d = pix_cnt_q + CW'(1);
        // Gradient spans two pixels, so the edge sits on the pixel in between.
        if ((pix_cnt_q >= CW'(2)) && (mag > 16'(threshold)) &&
            (peak_cnt_q < CNW'(MAX_PEAKS))) begin
          peak_pos_d[peak_cnt_q[IW-1:0]] = 8'(pix_cnt_q) - 8'd1;
          peak_mag_d[peak_cnt_q[IW-1:0]] = mag[MW-1:0];
          peak_cnt_d = peak_cnt_q + CNW'(1);
        end
        if (pix_cnt_q == CW'(N_PIX - 1)) state_d = S_SELECT;
      end
      S_SELECT: if (sel_done) state_d = S_CALC;
      S_CALC: begin
        state_d = S_SEND;
        if (sel_found) begin
`ifdef LANE_SMOOTH_EN
          tx_data_d = 8'((9'(last_center_q) + 9'(centre) + 9'd1) >> 1);
`else
          tx_data_d = centre;
`endif
          conf_d     = sat_add8(16'(peak_mag_q[sel_best_i] >> 1),
                                16'(peak_mag_q[sel_best_j] >> 1));
          lost_cnt_d = '0;
        end else begin
          tx_data_d = last_center_q;
          conf_d    = '0;
          if (lost_cnt_q < 8'(LOST_LIMIT)) lost_cnt_d = lost_cnt_q + 8'd1;
        end
      end
      S_SEND: if (bus.out_ready) begin
        state_d       = S_IDLE;
        last_center_d = (lost_cnt_q == 8'(LOST_LIMIT)) ? HALF : tx_data_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      peak_cnt_q    <= '0;
      peak_pos_q    <= '{default: '0};
      peak_mag_q    <= '{default: '0};
      last_center_q <= HALF;
      lost_cnt_q    <= '0;
      tx_data_q     <= '0;
      conf_q        <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      peak_cnt_q    <= peak_cnt_d;
      peak_pos_q    <= peak_pos_d;
      peak_mag_q    <= peak_mag_d;
      last_center_q <= last_center_d;
      lost_cnt_q    <= lost_cnt_d;
      tx_data_q     <= tx_data_d;
      conf_q        <= conf_d;
    end
  end

  assign bus.rx_ready   = (state_q == S_RECEIVE);
  assign bus.out_valid  = (state_q == S_SEND);
  assign bus.tx_data    = tx_data_q;
  assign bus.confidence = conf_q;
  assign bus.lane_lost  = (lost_cnt_q == 8'(LOST_LIMIT));
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_lane_tracker.sv
// Directed self-checking bench for lane_tracker (32 pixels, 4 peak slots, lost limit 4).
module tb_lane_tracker;

`ifdef LANE_SMOOTH_EN
  localparam int EXP_B = 18;
  localparam int EXP_C = 15;
`else
  localparam int EXP_B = 20;
  localparam int EXP_C = 12;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] threshold;
  logic [7:0] min_width;
  logic [7:0] max_width;
  logic       busy;

  lane_tracker_if #(.PIX_W(8)) bus ();

  lane_tracker #(.N_PIX(32), .PIX_W(8), .MAX_PEAKS(4), .LOST_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .threshold (threshold),
    .min_width (min_width),
    .max_width (max_width),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         checks_total  = 0;
  int         checks_passed = 0;
  logic [7:0] row_pix [32];
  int         lat;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clearRow();
    for (int i = 0; i < 32; i++) row_pix[i] = 8'd0;
  endtask

  // Sends one row; cycles counts from the cycle carrying the last pixel (=1) to out_valid.
  task automatic applyStimulus(output int cycles);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.rx_data  = row_pix[k];
      bus.rx_valid = 1'b1;
      if (!bus.rx_ready) checkOutput("rx_ready_in_receive", int'(bus.rx_ready), 1);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    cycles = 1;
    while (!bus.out_valid && cycles < 64) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic takeResult();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int exp_lat, input int exp_tx,
                             input int exp_conf, input int exp_lost);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_tx_data"}, int'(bus.tx_data), exp_tx);
    checkOutput({tag, "_confidence"}, int'(bus.confidence), exp_conf);
    checkOutput({tag, "_lane_lost"}, int'(bus.lane_lost), exp_lost);
  endtask

  task automatic loadRowA();
    clearRow();
    row_pix[10] = 8'd200;
    row_pix[22] = 8'd200;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    threshold     = 9'd100;
    min_width     = 8'd4;
    max_width     = 8'd20;
    bus.rx_data   = 8'd0;
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rx_ready", int'(bus.rx_ready), 0);
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_tx_data", int'(bus.tx_data), 0);
    checkOutput("reset_confidence", int'(bus.confidence), 0);
    checkOutput("reset_lane_lost", int'(bus.lane_lost), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_out_valid", int'(bus.out_valid), 0);
    checkOutput("idle_tx_data", int'(bus.tx_data), 0);

    // Peaks 9,11,21,23: pairs (9,23) and (11,21) both centre 16; earlier one wins.
    loadRowA();
    applyStimulus(lat);
    checkResult("rowA", 8, 16, 200, 0);
    takeResult();

    // Empty rows: no pair, centre held, lost counter walks up to the limit.
    for (int r = 1; r <= 4; r++) begin
      clearRow();
      applyStimulus(lat);
      checkResult($sformatf("zero_row%0d", r), 3, 16, 0, (r == 4) ? 1 : 0);
      takeResult();
    end

    // Peaks 9,11,30 only: pixel 20 gives magnitude 100, equal to threshold, not stored.
    clearRow();
    row_pix[10] = 8'd200;
    row_pix[20] = 8'd100;
    row_pix[31] = 8'd200;
    applyStimulus(lat);
    checkResult("rowB", 5, EXP_B, 200, 0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_out_valid", c), int'(bus.out_valid), 1);
      checkOutput($sformatf("stall%0d_tx_data", c), int'(bus.tx_data), EXP_B);
      checkOutput($sformatf("stall%0d_confidence", c), int'(bus.confidence), 200);
    end
    start = 1'b0;
    takeResult();
    checkOutput("after_send_out_valid", int'(bus.out_valid), 0);
    checkOutput("after_send_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("start_in_send_ignored", int'(busy), 0);

    // Six peaks; only 2,4,19,21 kept. Best (4,21) centre 12, conf 65+125.
    clearRow();
    row_pix[3]  = 8'd130;
    row_pix[20] = 8'd250;
    row_pix[28] = 8'd200;
    applyStimulus(lat);
    checkResult("rowC", 8, EXP_C, 190, 0);
    takeResult();

    // Reset in the middle of a row clears everything without waiting for a clock.
    loadRowA();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.rx_data  = row_pix[k];
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rx_ready", int'(bus.rx_ready), 0);
    checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_tx_data", int'(bus.tx_data), 0);
    checkOutput("midrst_confidence", int'(bus.confidence), 0);
    checkOutput("midrst_lane_lost", int'(bus.lane_lost), 0);
    bus.rx_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_idle_busy", int'(busy), 0);

    // last_center is back to 16, otherwise centre 15 would be chosen.
    loadRowA();
    applyStimulus(lat);
    checkResult("rowA_after_reset", 8, 16, 200, 0);
    takeResult();

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
